cpu_fetch_decode_pipe: RTL and testbench

- Parametrised two-stage instruction front end: fetch (PC plus instruction memory) and decode (field extraction plus register-file read).
- Sits between the code memory and the execute stage.
- Replaces the alternating fetch/decode state toggle with a true pipeline: one instruction per cycle, valid/ready backpressure, decode-stage unconditional-branch redirect, execute-stage redirect/flush, and a writeback port with read bypass.

---
 rtl/cpu_fetch_decode_pipe.sv | 147 ++++++++++++++
 tb/tb_cpu_fetch_decode_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_decode_pipe.sv
// Two-stage instruction front end: fetch (PC + instruction memory) and decode
// (field extraction + register read) with valid/ready backpressure and redirects.
module cpu_fetch_decode_pipe #(
  parameter int              WIDTH      = 32,
  parameter int              INST_COUNT = 64,
  parameter int              REG_COUNT  = 16,
  parameter string           CODE_FILE  = "cpu/code.hex",
  parameter string           REG_FILE   = "cpu/regfile_init.hex",
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             wb_en,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_inst,
  output logic [3:0]       out_rn,
  output logic [3:0]       out_rd,
  output logic [WIDTH-1:0] out_rn_val,
  output logic [WIDTH-1:0] out_rd_val,
  output logic             out_branch_taken
);
  localparam int IAW = (INST_COUNT > 1) ? $clog2(INST_COUNT) : 1;

  logic [WIDTH-1:0] imem [INST_COUNT];
  logic [WIDTH-1:0] rf   [REG_COUNT];

  logic [WIDTH-1:0]      pc_q, pc_d;
  logic                  f_valid_q, f_valid_d;
  logic [WIDTH-1:0]      f_pc_q, f_pc_d;
  logic [WIDTH-1:0]      f_inst_q, f_inst_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_pc_q, out_pc_d;
  logic [WIDTH-1:0]      out_inst_q, out_inst_d;
  logic [1:0][3:0]       out_idx_q, out_idx_d;   // [0]=Rn, [1]=Rd
  logic [1:0][WIDTH-1:0] out_val_q, out_val_d;
  logic                  out_br_q, out_br_d;

  logic                  adv;
  logic                  in_range;
  logic [WIDTH-1:0]      fetch_word;
  logic [1:0][3:0]       f_idx;
  logic [1:0][WIDTH-1:0] f_val;
  logic                  f_br;
  logic [WIDTH-1:0]      br_tgt;

  assign adv        = !out_valid_q || out_ready;
  assign in_range   = (pc_q >> 2) < WIDTH'(INST_COUNT);
  assign fetch_word = in_range ? imem[pc_q[IAW+1:2]] : '0;
  assign f_idx[0]   = f_inst_q[19:16];
  assign f_idx[1]   = f_inst_q[15:12];
  assign f_br       = f_valid_q && (f_inst_q[27:26] == 2'b10) && (f_inst_q[31:28] == 4'hE);
  assign br_tgt     = f_pc_q + WIDTH'(8) + {{(WIDTH-26){f_inst_q[23]}}, f_inst_q[23:0], 2'b00};

  // Index 15 reads as PC+8; a same-cycle writeback wins over the stored value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      f_val[p] = rf[f_idx[p]];
      if (wb_en && (wb_addr == f_idx[p])) f_val[p] = wb_data;
      if (f_idx[p] == 4'hF)               f_val[p] = f_pc_q + WIDTH'(8);
    end
  end

  always_comb begin
    pc_d        = pc_q;
    f_valid_d   = f_valid_q;
    f_pc_d      = f_pc_q;
    f_inst_d    = f_inst_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_idx_d   = out_idx_q;
    out_val_d   = out_val_q;
    out_br_d    = out_br_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      f_valid_d   = 1'b0;
      out_valid_d = 1'b0;
      out_br_d    = 1'b0;
    end else if (adv) begin
      pc_d        = pc_q + WIDTH'(4);
      f_pc_d      = pc_q;
      f_inst_d    = fetch_word;
      f_valid_d   = 1'b1;
      out_valid_d = f_valid_q;
      if (f_valid_q) begin
        out_pc_d   = f_pc_q;
        out_inst_d = f_inst_q;
        out_idx_d  = f_idx;
        out_val_d  = f_val;
        out_br_d   = f_br;
        // Taken branch squashes the sequential fetch issued this same cycle.
        if (f_br) begin
          pc_d      = br_tgt;
          f_valid_d = 1'b0;
        end
      end
    end else begin
      for (int p = 0; p < 2; p++)
        if (wb_en && (wb_addr != 4'hF) && (wb_addr == out_idx_q[p])) out_val_d[p] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      pc_q        <= RESET_PC;
      f_valid_q   <= 1'b0;
      f_pc_q      <= '0;
      f_inst_q    <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      out_idx_q   <= '0;
      out_val_q   <= '0;
      out_br_q    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      f_valid_q   <= f_valid_d;
      f_pc_q      <= f_pc_d;
      f_inst_q    <= f_inst_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_idx_q   <= out_idx_d;
      out_val_q   <= out_val_d;
      out_br_q    <= out_br_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset && wb_en) rf[wb_addr] <= wb_data;
  end

  assign out_valid        = out_valid_q;
  assign out_pc           = out_pc_q;
  assign out_inst         = out_inst_q;
  assign out_rn           = out_idx_q[0];
  assign out_rd           = out_idx_q[1];
  assign out_rn_val       = out_val_q[0];
  assign out_rd_val       = out_val_q[1];
  assign out_branch_taken = out_br_q;
endmodule

// File: tb/tb_cpu_fetch_decode_pipe.sv
// Bench for cpu_fetch_decode_pipe: program-order reference model with
// architectural register file, directed scenarios, then randomized traffic.
module tb_cpu_fetch_decode_pipe;
  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_pc, out_inst, out_rn_val, out_rd_val;
  logic [3:0]  out_rn, out_rd;
  logic        out_branch_taken;

  cpu_fetch_decode_pipe #(.WIDTH(32), .INST_COUNT(64), .REG_COUNT(16),
                          .CODE_FILE(""), .REG_FILE(""), .RESET_PC(32'h0)) dut (
    .clk(clk), .nreset(nreset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_rn(out_rn),
    .out_rd(out_rd), .out_rn_val(out_rn_val), .out_rd_val(out_rd_val),
    .out_branch_taken(out_branch_taken));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_m [64];
  logic [31:0] rf_m  [16];
  logic        mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return (pc < 32'd256) ? mem_m[pc[7:2]] : 32'h0;
  endfunction

  function automatic logic [31:0] opnd(input logic [3:0] idx, input logic [31:0] pc);
    return (idx == 4'hF) ? pc + 32'd8 : rf_m[idx];
  endfunction

  // Reference: instructions appear in program order; operands always equal the
  // architectural register contents as of the most recent edge.
  logic        s_valid = 1'b0, s_br = 1'b0;
  logic [31:0] s_pc = '0, s_inst = '0, exp_pc = '0;
  always @(posedge clk) begin
    logic c_rst, c_rdr, c_wb, c_rdy, e_br;
    logic [3:0]  c_wa;
    logic [31:0] c_wd, c_rpc, e_inst;
    c_rst = nreset; c_rdr = redirect_valid; c_rpc = redirect_pc; c_rdy = out_ready;
    c_wb = wb_en; c_wa = wb_addr; c_wd = wb_data;
    #1;
    if (c_rst) begin
      exp_pc = 32'h0;
      if (mon_on) begin
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_misc", out_rn_val | out_rd_val | {23'b0, out_rn, out_rd, out_branch_taken}, 32'h0);
      end
    end else begin
      if (c_wb) rf_m[c_wa] = c_wd;
      if (c_rdr) begin
        exp_pc = c_rpc;
        if (mon_on) chk("redir_valid", {31'b0, out_valid}, 32'h0);
      end else if (out_valid && mon_on) begin
        if (s_valid && !c_rdy) begin
          chk("hold_pc", out_pc, s_pc);
          chk("hold_inst", out_inst, s_inst);
          chk("hold_br", {31'b0, out_branch_taken}, {31'b0, s_br});
        end else begin
          e_inst = mem_at(exp_pc);
          e_br   = (e_inst[31:28] == 4'hE) && (e_inst[27:26] == 2'b10);
          chk("seq_pc", out_pc, exp_pc);
          chk("seq_inst", out_inst, e_inst);
          chk("seq_fields", {24'b0, out_rn, out_rd}, {24'b0, e_inst[19:16], e_inst[15:12]});
          chk("seq_br", {31'b0, out_branch_taken}, {31'b0, e_br});
          if (e_br) exp_pc = exp_pc + 32'd8 + 32'(int'($signed(e_inst[23:0])) * 4);
          else      exp_pc = exp_pc + 32'd4;
        end
        chk("rn_val", out_rn_val, opnd(out_rn, out_pc));
        chk("rd_val", out_rd_val, opnd(out_rd, out_pc));
      end
    end
    s_valid = out_valid; s_pc = out_pc; s_inst = out_inst; s_br = out_branch_taken;
  end

  task automatic put_mem(input int i, input logic [31:0] w);
    mem_m[i] = w;
    dut.imem[i] = w;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_alu_prog();
    for (int i = 0; i < 64; i++)
      put_mem(i, 32'hE0800000 | (32'(i % 15) << 16) | (32'((i + 1) % 15) << 12) | 32'(i));
    put_mem(4, 32'hE08F5000);  // Rn=15
    put_mem(5, 32'hE0836000);  // Rn=3
  endtask

  task automatic release_reset();
    nreset = 1'b1; tick(); nreset = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int off;
    load_alu_prog();
    tick(); tick();
    // Register file is not cleared by reset: seed it through the write port.
    nreset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wb_en = 1'b1; wb_addr = 4'(i); wb_data = 32'h1000_0000 + 32'(i) * 32'h111;
      tick();
    end
    wb_en = 1'b0;
    mon_on = 1'b1;

    // Phase A: sequential flow, stall, PC-relative read, bypass, redirect
    release_reset();
    chk("a_rst_pc", out_pc, 32'h0);
    tick(); chk("a_p1_valid", {31'b0, out_valid}, 32'h0);
    tick(); chk("a_p2_valid", {31'b0, out_valid}, 32'h1); chk("a_p2_pc", out_pc, 32'h0);
    chk("a_p2_rn_val", out_rn_val, 32'h1000_0000);
    tick(); chk("a_p3_pc", out_pc, 32'h4);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); chk("a_stall_pc", out_pc, 32'h4); end
    out_ready = 1'b1;
    tick(); chk("a_rel_pc8", out_pc, 32'h8);
    tick(); chk("a_rel_pc12", out_pc, 32'hC);
    tick(); chk("a_r15_pc", out_pc, 32'h10); chk("a_r15_val", out_rn_val, 32'h18);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF;
    tick(); wb_en = 1'b0;
    chk("a_byp_pc", out_pc, 32'h14); chk("a_byp_val", out_rn_val, 32'hDEADBEEF);
    out_ready = 1'b0;
    tick(); chk("a_hold_pc", out_pc, 32'h14);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick(); redirect_valid = 1'b0; out_ready = 1'b1;
    chk("a_rdr_v0", {31'b0, out_valid}, 32'h0);
    tick(); chk("a_rdr_v1", {31'b0, out_valid}, 32'h0);
    tick(); chk("a_rdr_v2", {31'b0, out_valid}, 32'h1); chk("a_rdr_pc", out_pc, 32'h20);

    // Phase B: decode-stage branch at 0x8 (B +2 -> 0x18)
    nreset = 1'b1; put_mem(2, 32'hEA000002); tick();
    nreset = 1'b0;
    tick(); tick(); chk("b_pc0", out_pc, 32'h0);
    tick(); chk("b_pc4", out_pc, 32'h4);
    tick(); chk("b_br_pc", out_pc, 32'h8); chk("b_br_taken", {31'b0, out_branch_taken}, 32'h1);
    tick(); chk("b_bubble", {31'b0, out_valid}, 32'h0);
    tick(); chk("b_tgt_valid", {31'b0, out_valid}, 32'h1); chk("b_tgt_pc", out_pc, 32'h18);

    // Phase C: reset while the branch waits in fetch; writeback is blocked by reset
    release_reset();
    tick(); tick(); tick(); chk("c_pc4", out_pc, 32'h4);
    nreset = 1'b1; wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h12345678;
    tick(); nreset = 1'b0; wb_en = 1'b0;
    chk("c_rst_valid", {31'b0, out_valid}, 32'h0); chk("c_rst_br", {31'b0, out_branch_taken}, 32'h0);
    tick(); chk("c_v1", {31'b0, out_valid}, 32'h0);
    tick(); chk("c_v2", {31'b0, out_valid}, 32'h1); chk("c_pc_restart", out_pc, 32'h0);

    // Phase D: random program and random traffic
    nreset = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        off = int'($urandom_range(0, 10)) - 4;
        w = ($urandom_range(0, 3) == 0) ? 32'h0A000000 : 32'hEA000000;
        w[23:0] = 24'(off);
      end else begin
        w = $urandom;
        if (w[27:26] == 2'b10 && w[31:28] == 4'hE) w[31:28] = 4'h0;
      end
      put_mem(i, w);
    end
    tick(); nreset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      nreset         = ($urandom_range(0, 199) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      wb_en          = ($urandom_range(0, 2) == 0);
      wb_addr        = 4'($urandom_range(0, 15));
      wb_data        = $urandom;
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 511))
                                                   : 32'($urandom_range(0, 79)) << 2;
      tick();
    end
    nreset = 1'b0; redirect_valid = 1'b0; wb_en = 1'b0;
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
